// File: rtl/vga_pkg.sv
// Shared VGA timing constants, test-pattern codes and sequencer FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

  localparam int COORD_W  = 11;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  // Pattern codes understood by the top-level colour mux
  localparam logic [1:0] PAT_QUAD    = 2'd0;
  localparam logic [1:0] PAT_BARS    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_SOLID   = 2'd3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } seq_state_t;

  // Step to the next pattern, wrapping after the last one in rotation
  function automatic logic [1:0] next_pattern(input logic [1:0] cur, input int num);
    return (cur == 2'(num - 1)) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/vga_frame_edge.sv
// Detects the first line of vertical blanking and emits a one-cycle frame tick.
// Latency: o_tick_c is combinational; o_frame_tick is o_tick_c delayed by 1 cycle.
// Backpressure: none, the tick is a free-running pulse.
module vga_frame_edge #(
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [vga_pkg::COORD_W-1:0] i_y_pos,
  output logic                        o_tick_c,
  output logic                        o_frame_tick
);
  import vga_pkg::*;

  localparam logic [COORD_W-1:0] V_LINE = COORD_W'(V_ACTIVE);

  logic [COORD_W-1:0] r_y_prev;
  logic               r_frame_tick;

  // y_prev starts at the blanking line so a y_pos already parked there at release is not a new frame
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_y_prev     <= V_LINE;
      r_frame_tick <= 1'b0;
    end else begin
      r_y_prev     <= i_y_pos;
      r_frame_tick <= o_tick_c;
    end
  end

  assign o_tick_c     = (i_y_pos == V_LINE) && (r_y_prev != V_LINE);
  assign o_frame_tick = r_frame_tick;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Chooses the active test pattern: auto-rotates every DWELL_FRAMES frames, with pause and manual step.
// Latency: pattern_sel/frame_cnt/frame_tick all update on the edge after y_pos first hits V_ACTIVE.
// Backpressure: none; button pulses are always accepted, a second step while one is pending is dropped.
module vga_pattern_sequencer #(
  parameter int V_ACTIVE     = vga_pkg::V_ACTIVE,
  parameter int DWELL_FRAMES = 120,
  parameter int NUM_PATTERNS = 4,
  parameter int FCNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [vga_pkg::COORD_W-1:0] y_pos,
  input  logic                        btn_next,
  input  logic                        btn_pause,
  output logic [1:0]                  pattern_sel,
  output logic                        frame_tick,
  output logic                        paused,
  output logic [FCNT_W-1:0]           frame_cnt
);
  import vga_pkg::*;

  localparam int                DW_W       = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL_FRAMES - 1);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [DW_W-1:0]   r_dwell;
  logic [DW_W-1:0]   w_dwell_nxt;
  logic              r_pending;
  logic              w_pend_nxt;
  logic [1:0]        r_pat;
  logic [1:0]        w_pat_nxt;
  logic [FCNT_W-1:0] r_fcnt;
  logic [FCNT_W-1:0] w_fcnt_nxt;
  logic              r_paused;
  logic              w_advance;
  logic              w_tick_c;
  logic              w_frame_tick;

  vga_frame_edge #(
    .V_ACTIVE (V_ACTIVE)
  ) u_frame_edge (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_y_pos      (y_pos),
    .o_tick_c     (w_tick_c),
    .o_frame_tick (w_frame_tick)
  );

  // FSM state register; paused mirrors the state as a registered flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_paused <= (w_state_nxt == ST_PAUSED);
    end
  end

  // Next state and datapath: the tick is judged in the current state before a pause toggle lands
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_dwell_nxt = r_dwell;
    w_pend_nxt  = r_pending;
    w_fcnt_nxt  = r_fcnt;
    w_advance   = 1'b0;
    if (w_tick_c) begin
      w_fcnt_nxt = r_fcnt + FCNT_W'(1);
      w_pend_nxt = 1'b0;
      // A step pressed on the tick cycle itself is honoured at this tick
      if (r_pending || btn_next) begin
        w_advance = 1'b1;
      end
      if (r_state == ST_RUN) begin
        if (r_dwell == DWELL_LAST) begin
          w_advance = 1'b1;
        end else begin
          w_dwell_nxt = r_dwell + DW_W'(1);
        end
      end
      // Manual and automatic advance at the same tick collapse into a single step
      if (w_advance) begin
        w_pat_nxt   = next_pattern(r_pat, NUM_PATTERNS);
        w_dwell_nxt = '0;
      end
    end else if (btn_next) begin
      w_pend_nxt = 1'b1;
    end
    if (btn_pause) begin
      if (r_state == ST_RUN) begin
        w_state_nxt = ST_PAUSED;
      end else begin
        w_state_nxt = ST_RUN;
        w_dwell_nxt = '0;
      end
    end
  end

  // Datapath registers; pattern_sel only moves on a tick edge (or reset)
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dwell   <= '0;
      r_pending <= 1'b0;
      r_pat     <= PAT_QUAD;
      r_fcnt    <= '0;
    end else begin
      r_dwell   <= w_dwell_nxt;
      r_pending <= w_pend_nxt;
      r_pat     <= w_pat_nxt;
      r_fcnt    <= w_fcnt_nxt;
    end
  end

  assign pattern_sel = r_pat;
  assign frame_tick  = w_frame_tick;
  assign paused      = r_paused;
  assign frame_cnt   = r_fcnt;

endmodule
